// File: rtl/period_meter.sv
// ---------------------------------------------------------------------------------------------
// period_meter
//
// Measures the period and high time of a slow, asynchronous digital input in clk cycles. The
// input is synchronised, rising edges are detected, and each complete period between two rising
// edges is published on period/high_time together with a one-cycle valid strobe. The first,
// partial period after enabling is always discarded. A period that does not fit in COUNT_WIDTH
// bits sets the sticky overflow flag and re-arms the measurement.
//
// Parameters:
//   COUNT_WIDTH  width of the cycle counters and of all count outputs
//   SYNC_STAGES  input synchroniser depth, legal range 2..4
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          measurement enable; low returns to idle and clears overflow
//   sig_in      asynchronous signal under measurement
//   period      clk cycles between the last two rising edges of sig_in
//   high_time   clk cycles sig_in was high within that period
//   period_min  smallest period since leaving idle   (PERIOD_METER_MINMAX_EN only)
//   period_max  largest period since leaving idle    (PERIOD_METER_MINMAX_EN only)
//   valid       one-cycle pulse when period/high_time update
//   overflow    sticky: a counter saturated before the next rising edge
//
// Build option:
//   PERIOD_METER_MINMAX_EN  when defined, adds period_min/period_max tracking.
// ---------------------------------------------------------------------------------------------

module period_meter #(
   parameter int unsigned COUNT_WIDTH = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   sig_in,
   output logic [COUNT_WIDTH-1:0] period,
   output logic [COUNT_WIDTH-1:0] high_time,
`ifdef PERIOD_METER_MINMAX_EN
   output logic [COUNT_WIDTH-1:0] period_min,
   output logic [COUNT_WIDTH-1:0] period_max,
`endif
   output logic                   valid,
   output logic                   overflow
);

   localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StMeasure
   } state_e;

   // ------------------------------------------------------------------------------------------
   // Synchroniser and rising-edge detect
   // ------------------------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   prev_q;
   logic                   rise_q;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      end
   end

   // rise is registered so the FSM sees it in the same cycle as prev_q, which then carries the
   // level of the cycle the edge belongs to; high-time accumulation uses prev_q for that reason.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         prev_q <= s;
         rise_q <= s & ~prev_q;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Measurement FSM
   // ------------------------------------------------------------------------------------------
   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [COUNT_WIDTH-1:0] hcnt_q, hcnt_d;
   logic [COUNT_WIDTH-1:0] period_q, period_d;
   logic [COUNT_WIDTH-1:0] high_q, high_d;
   logic                   valid_q, valid_d;
   logic                   ovf_q, ovf_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hcnt_d   = hcnt_q;
      period_d = period_q;
      high_d   = high_q;
      valid_d  = 1'b0;
      ovf_d    = ovf_q;

      if (!en) begin
         // Disable wins over everything, including a rise in the same cycle.
         state_d = StIdle;
         cnt_d   = '0;
         hcnt_d  = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               cnt_d   = '0;
               hcnt_d  = '0;
               state_d = StArmed;
            end

            StArmed: begin
               // Anything before the first rise is a partial period and is thrown away.
               if (rise_q) begin
                  cnt_d   = CntOne;
                  hcnt_d  = CntOne;
                  state_d = StMeasure;
               end else begin
                  cnt_d   = '0;
                  hcnt_d  = '0;
               end
            end

            StMeasure: begin
               if (rise_q) begin
                  // Rise takes priority over saturation, so a full-scale period is still stored.
                  period_d = cnt_q;
                  high_d   = hcnt_q;
                  valid_d  = 1'b1;
                  cnt_d    = CntOne;
                  hcnt_d   = CntOne;
               end else if (cnt_q == '1) begin
                  ovf_d   = 1'b1;
                  state_d = StArmed;
               end else begin
                  cnt_d = cnt_q + CntOne;
                  if (prev_q) begin
                     hcnt_d = hcnt_q + CntOne;
                  end
               end
            end

            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         hcnt_q   <= '0;
         period_q <= '0;
         high_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hcnt_q   <= hcnt_d;
         period_q <= period_d;
         high_q   <= high_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   assign period    = period_q;
   assign high_time = high_q;
   assign valid     = valid_q;
   assign overflow  = ovf_q;

`ifdef PERIOD_METER_MINMAX_EN
   // ------------------------------------------------------------------------------------------
   // Min/max period tracking
   // ------------------------------------------------------------------------------------------
   logic                   first_q, first_d;
   logic [COUNT_WIDTH-1:0] min_q, min_d;
   logic [COUNT_WIDTH-1:0] max_q, max_d;

   always_comb begin
      first_d = first_q;
      min_d   = min_q;
      max_d   = max_q;

      if (!en || state_q == StIdle) begin
         // Any pass through idle makes the next stored period the new baseline.
         first_d = 1'b1;
      end else if (valid_d) begin
         if (first_q) begin
            min_d   = cnt_q;
            max_d   = cnt_q;
            first_d = 1'b0;
         end else begin
            if (cnt_q < min_q) begin
               min_d = cnt_q;
            end
            if (cnt_q > max_q) begin
               max_d = cnt_q;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_q <= 1'b1;
         min_q   <= '0;
         max_q   <= '0;
      end else begin
         first_q <= first_d;
         min_q   <= min_d;
         max_q   <= max_d;
      end
   end

   assign period_min = min_q;
   assign period_max = max_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// ---------------------------------------------------------------------------------------------
// tb_period_meter
//
// Self-checking bench for period_meter. Each scenario builds a per-cycle input waveform, plays
// it one level per clk, and compares the observed valid strobes against a reference computed
// from the waveform itself: periods are distances between rising-edge indices, high time is the
// number of high samples in between, and a gap longer than the counter range means overflow.
// Build with +define+PERIOD_METER_MINMAX_EN to cover the min/max outputs as well.
// ---------------------------------------------------------------------------------------------

module tb_period_meter;

   localparam int CW   = 6;
   localparam int SYNC = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          en     = 1'b0;
   logic          sig_in = 1'b0;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          valid;
   logic          overflow;
`ifdef PERIOD_METER_MINMAX_EN
   logic [CW-1:0] period_min;
   logic [CW-1:0] period_max;
`endif

   int passed = 0;
   int total  = 0;
   int cyc    = 0;

   bit wave[$];
   int samp[$];
   int obs_p[$], obs_h[$], obs_t[$];
   int exp_p[$], exp_h[$], exp_i[$];
   bit exp_ovf;

   period_meter #(
      .COUNT_WIDTH(CW),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .sig_in    (sig_in),
      .period    (period),
      .high_time (high_time),
`ifdef PERIOD_METER_MINMAX_EN
      .period_min(period_min),
      .period_max(period_max),
`endif
      .valid     (valid),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (valid === 1'b1) begin
         obs_p.push_back(int'(period));
         obs_h.push_back(int'(high_time));
         obs_t.push_back(cyc);
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------------------------------------------------------- waveform construction
   task automatic seg(input int hi, input int lo);
      repeat (hi) wave.push_back(1'b1);
      repeat (lo) wave.push_back(1'b0);
   endtask

   // Final rise so the last full period gets measured, followed by a short low tail.
   task automatic close_wave();
      wave.push_back(1'b1);
      repeat (6) wave.push_back(1'b0);
   endtask

   // Index i of the wave is sampled by the clk edge that makes cyc == samp[i].
   task automatic play_wave();
      obs_p.delete(); obs_h.delete(); obs_t.delete(); samp.delete();
      for (int i = 0; i < wave.size(); i++) begin
         @(negedge clk);
         sig_in = wave[i];
         samp.push_back(cyc + 1);
      end
      repeat (SYNC + 3) @(negedge clk);
   endtask

   task automatic restart();
      @(negedge clk);
      en     = 1'b0;
      sig_in = 1'b0;
      repeat (SYNC + 4) @(negedge clk);
      en = 1'b1;
      repeat (2) @(negedge clk);
      wave.delete();
   endtask

   // ---------------------------------------------------------------- reference model
   function automatic void model_wave();
      bit have;
      bit prevl;
      int ref_i;
      int hc;
      exp_p.delete(); exp_h.delete(); exp_i.delete();
      exp_ovf = 1'b0;
      have    = 1'b0;
      prevl   = 1'b0;
      ref_i   = 0;
      for (int i = 0; i < wave.size(); i++) begin
         bit is_rise;
         is_rise = wave[i] && !prevl;
         if (have && !is_rise && (i - ref_i) >= MAXC) begin
            exp_ovf = 1'b1;
            have    = 1'b0;
         end
         if (is_rise) begin
            if (have) begin
               hc = 0;
               for (int j = ref_i; j < i; j++) hc += int'(wave[j]);
               exp_p.push_back(i - ref_i);
               exp_h.push_back(hc);
               exp_i.push_back(i);
            end
            have  = 1'b1;
            ref_i = i;
         end
         prevl = wave[i];
      end
   endfunction

   // ---------------------------------------------------------------- scenarios
   task automatic test_reset();
      rst_n  = 1'b0;
      en     = 1'b0;
      sig_in = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (period !== '0) $display("FAIL reset period: got %0d want 0", period); else passed++;
      total++; if (high_time !== '0) $display("FAIL reset high_time: got %0d want 0", high_time); else passed++;
      total++; if (valid !== 1'b0) $display("FAIL reset valid: got %b want 0", valid); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL reset overflow: got %b want 0", overflow); else passed++;
`ifdef PERIOD_METER_MINMAX_EN
      total++; if (period_min !== '0 || period_max !== '0)
         $display("FAIL reset minmax: got %0d/%0d want 0/0", period_min, period_max); else passed++;
`endif
      rst_n = 1'b1;
      obs_p.delete(); obs_h.delete(); obs_t.delete();
      repeat (12) begin @(negedge clk); sig_in = ~sig_in; end
      repeat (6) @(negedge clk);
      total++; if (obs_p.size() !== 0)
         $display("FAIL disabled_valid: got %0d strobes want 0", obs_p.size()); else passed++;
   endtask

   task automatic test_divider();
      restart();
      repeat (6) seg(6, 6);
      close_wave();
      play_wave();
      model_wave();
      total++; if (obs_p.size() !== exp_p.size())
         $display("FAIL divider count: got %0d want %0d", obs_p.size(), exp_p.size()); else passed++;
      for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
         total++; if (obs_p[k] !== 12 || obs_h[k] !== 6)
            $display("FAIL divider meas%0d: got %0d/%0d want 12/6", k, obs_p[k], obs_h[k]); else passed++;
         total++; if (obs_t[k] !== samp[exp_i[k]] + SYNC + 1)
            $display("FAIL divider latency%0d: got cyc %0d want %0d", k, obs_t[k],
                     samp[exp_i[k]] + SYNC + 1); else passed++;
      end
      total++; if (overflow !== 1'b0) $display("FAIL divider overflow: got %b want 0", overflow); else passed++;
   endtask

   task automatic test_duty();
      restart();
      repeat (6) seg(3, 7);
      close_wave();
      play_wave();
      model_wave();
      total++; if (obs_p.size() !== exp_p.size())
         $display("FAIL duty count: got %0d want %0d", obs_p.size(), exp_p.size()); else passed++;
      for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
         total++; if (obs_p[k] !== 10 || obs_h[k] !== 3)
            $display("FAIL duty meas%0d: got %0d/%0d want 10/3", k, obs_p[k], obs_h[k]); else passed++;
         if (k > 0) begin
            total++; if (obs_t[k] - obs_t[k-1] !== 10)
               $display("FAIL duty spacing%0d: got %0d want 10", k, obs_t[k] - obs_t[k-1]); else passed++;
         end
      end
   endtask

   task automatic test_fastest();
      restart();
      repeat (10) seg(1, 1);
      close_wave();
      play_wave();
      model_wave();
      total++; if (obs_p.size() !== exp_p.size())
         $display("FAIL fastest count: got %0d want %0d", obs_p.size(), exp_p.size()); else passed++;
      for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
         total++; if (obs_p[k] !== 2 || obs_h[k] !== 1)
            $display("FAIL fastest meas%0d: got %0d/%0d want 2/1", k, obs_p[k], obs_h[k]); else passed++;
         total++; if (obs_t[k] !== samp[exp_i[k]] + SYNC + 1)
            $display("FAIL fastest latency%0d: got cyc %0d want %0d", k, obs_t[k],
                     samp[exp_i[k]] + SYNC + 1); else passed++;
      end
   endtask

   // Full-scale period is still stored; one cycle more overflows and re-arms.
   task automatic test_boundary();
      restart();
      seg(10, MAXC - 10);
      seg(10, MAXC - 10);
      seg(10, MAXC - 9);
      seg(4, 4);
      close_wave();
      play_wave();
      model_wave();
      total++; if (obs_p.size() !== exp_p.size())
         $display("FAIL boundary count: got %0d want %0d", obs_p.size(), exp_p.size()); else passed++;
      for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
         total++; if (obs_p[k] !== exp_p[k] || obs_h[k] !== exp_h[k])
            $display("FAIL boundary meas%0d: got %0d/%0d want %0d/%0d", k, obs_p[k], obs_h[k],
                     exp_p[k], exp_h[k]); else passed++;
      end
      total++; if (overflow !== exp_ovf)
         $display("FAIL boundary overflow: got %b want %b", overflow, exp_ovf); else passed++;
   endtask

   task automatic test_overflow();
      restart();
      wave.push_back(1'b1);
      repeat (100) wave.push_back(1'b0);
      repeat (5) seg(4, 4);
      close_wave();
      play_wave();
      model_wave();
      total++; if (obs_p.size() !== exp_p.size())
         $display("FAIL overflow count: got %0d want %0d", obs_p.size(), exp_p.size()); else passed++;
      for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
         total++; if (obs_p[k] !== 8 || obs_h[k] !== 4)
            $display("FAIL overflow meas%0d: got %0d/%0d want 8/4", k, obs_p[k], obs_h[k]); else passed++;
      end
      total++; if (overflow !== 1'b1) $display("FAIL overflow sticky: got %b want 1", overflow); else passed++;
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      total++; if (overflow !== 1'b0) $display("FAIL overflow clear: got %b want 0", overflow); else passed++;
      total++; if (period !== CW'(8)) $display("FAIL overflow hold: got %0d want 8", period); else passed++;
      @(negedge clk);
      en = 1'b1;
      // Constant-high input: one rise, then saturation and no strobe.
      restart();
      repeat (90) wave.push_back(1'b1);
      play_wave();
      total++; if (obs_p.size() !== 0)
         $display("FAIL const_high count: got %0d want 0", obs_p.size()); else passed++;
      total++; if (overflow !== 1'b1) $display("FAIL const_high overflow: got %b want 1", overflow); else passed++;
   endtask

   task automatic test_enable_drop();
      restart();
      seg(6, 6);
      seg(6, 6);
      seg(6, 3);
      play_wave();
      total++; if (period !== CW'(12)) $display("FAIL en_drop pre: got %0d want 12", period); else passed++;
      @(negedge clk);
      en = 1'b0;
      @(posedge clk);
      #1;
      total++; if (period !== CW'(12) || valid !== 1'b0)
         $display("FAIL en_drop hold: got %0d/%b want 12/0", period, valid); else passed++;
      @(negedge clk);
      en = 1'b1;
      wave.delete();
      seg(5, 5);
      seg(5, 5);
      close_wave();
      play_wave();
      model_wave();
      total++; if (obs_p.size() !== exp_p.size())
         $display("FAIL en_drop count: got %0d want %0d", obs_p.size(), exp_p.size()); else passed++;
      for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
         total++; if (obs_p[k] !== 10 || obs_h[k] !== 5)
            $display("FAIL en_drop meas%0d: got %0d/%0d want 10/5", k, obs_p[k], obs_h[k]); else passed++;
      end
   endtask

   task automatic test_reset_mid();
      restart();
      seg(6, 6);
      seg(6, 6);
      seg(4, 3);
      play_wave();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      total++; if (period !== '0 || high_time !== '0 || valid !== 1'b0 || overflow !== 1'b0)
         $display("FAIL rst_mid outputs: got %0d/%0d/%b/%b want 0/0/0/0", period, high_time, valid,
                  overflow); else passed++;
      #1 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      wave.delete();
      seg(7, 7);
      seg(7, 7);
      close_wave();
      play_wave();
      model_wave();
      total++; if (obs_p.size() !== exp_p.size())
         $display("FAIL rst_mid count: got %0d want %0d", obs_p.size(), exp_p.size()); else passed++;
      for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
         total++; if (obs_p[k] !== 14 || obs_h[k] !== 7)
            $display("FAIL rst_mid meas%0d: got %0d/%0d want 14/7", k, obs_p[k], obs_h[k]); else passed++;
         total++; if (obs_t[k] !== samp[exp_i[k]] + SYNC + 1)
            $display("FAIL rst_mid latency%0d: got cyc %0d want %0d", k, obs_t[k],
                     samp[exp_i[k]] + SYNC + 1); else passed++;
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         restart();
         for (int n = 0; n < 8; n++) begin
            int hi;
            int lo;
            hi = $urandom_range(1, 20);
            lo = ($urandom_range(0, 5) == 0) ? $urandom_range(40, 70) : $urandom_range(1, 20);
            seg(hi, lo);
         end
         close_wave();
         play_wave();
         model_wave();
         total++; if (obs_p.size() !== exp_p.size())
            $display("FAIL random%0d count: got %0d want %0d", r, obs_p.size(), exp_p.size());
         else passed++;
         for (int k = 0; k < exp_p.size() && k < obs_p.size(); k++) begin
            total++; if (obs_p[k] !== exp_p[k] || obs_h[k] !== exp_h[k])
               $display("FAIL random%0d meas%0d: got %0d/%0d want %0d/%0d", r, k, obs_p[k], obs_h[k],
                        exp_p[k], exp_h[k]); else passed++;
            total++; if (obs_t[k] !== samp[exp_i[k]] + SYNC + 1)
               $display("FAIL random%0d latency%0d: got cyc %0d want %0d", r, k, obs_t[k],
                        samp[exp_i[k]] + SYNC + 1); else passed++;
         end
         total++; if (overflow !== exp_ovf)
            $display("FAIL random%0d overflow: got %b want %b", r, overflow, exp_ovf); else passed++;
`ifdef PERIOD_METER_MINMAX_EN
         if (exp_p.size() > 0) begin
            int mn;
            int mx;
            mn = exp_p.min()[0];
            mx = exp_p.max()[0];
            total++; if (int'(period_min) !== mn || int'(period_max) !== mx)
               $display("FAIL random%0d minmax: got %0d/%0d want %0d/%0d", r, period_min,
                        period_max, mn, mx); else passed++;
         end
`endif
      end
   endtask

`ifdef PERIOD_METER_MINMAX_EN
   task automatic test_minmax();
      restart();
      seg(6, 6);
      seg(4, 4);
      seg(8, 8);
      close_wave();
      play_wave();
      total++; if (obs_p.size() !== 3)
         $display("FAIL minmax count: got %0d want 3", obs_p.size()); else passed++;
      total++; if (period_min !== CW'(8) || period_max !== CW'(16))
         $display("FAIL minmax values: got %0d/%0d want 8/16", period_min, period_max); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_divider();
      test_duty();
      test_fastest();
      test_boundary();
      test_overflow();
      test_enable_drop();
      test_reset_mid();
      test_random();
`ifdef PERIOD_METER_MINMAX_EN
      test_minmax();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
